// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: bus bundles, pipeline bundles,
// access sizes, exception codes and the stage FSM states.
package mem_stage_pkg;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef enum logic [1:0] {EXC_NONE, LOAD_MISALIGN, STORE_MISALIGN} exc_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        mem_read;
        logic        mem_write;
        msize_t      msize;
        logic        mem_unsigned;
        logic [63:0] alu_result;
        logic [63:0] rs2_val;
        logic [4:0]  rd;
        logic        regwrite;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        regwrite;
        exc_t        exc;
    } memory_data_t;

    function automatic logic [7:0] size_mask(input msize_t s);
        case (s)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // An access is aligned when the offset is a multiple of the access width.
    function automatic logic is_misaligned(input logic [2:0] off, input msize_t s);
        case (s)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the data bus: store strobe/data placement and
// load data extraction with sign or zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  addr,
    input  msize_t      msize,
    input  logic [63:0] rs2_val,
    input  logic        mem_unsigned,
    input  logic [63:0] raw,
    output logic [7:0]  strobe,
    output logic [63:0] store_data,
    output logic [63:0] load_data
);

    logic [63:0] shifted;

    always_comb begin
        strobe     = size_mask(msize) << addr;
        store_data = rs2_val << {addr, 3'b000};
        shifted    = raw >> {addr, 3'b000};
        case (msize)
            MSIZE1:  load_data = mem_unsigned ? {56'b0, shifted[7:0]}
                                              : {{56{shifted[7]}}, shifted[7:0]};
            MSIZE2:  load_data = mem_unsigned ? {48'b0, shifted[15:0]}
                                              : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE4:  load_data = mem_unsigned ? {32'b0, shifted[31:0]}
                                              : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-bus transaction per memory instruction,
// stalls upstream while it is outstanding, and presents the result on dataM.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    input  logic         csr_flush,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output memory_data_t dataM,
    output logic         handshake_stall,
    output logic         data_ok
);

    mem_state_t  state_q, state_d, cur_state;
    logic        flushed_q, flushed_d;
    logic [63:0] rdata_q, rdata_d;

    logic        access, misaligned, squash;
    logic [7:0]  strobe;
    logic [63:0] store_data, load_data;
    dbus_req_t   new_req;

    mem_align u_align (
        .addr         (dataE.alu_result[2:0]),
        .msize        (dataE.msize),
        .rs2_val      (dataE.rs2_val),
        .mem_unsigned (dataE.mem_unsigned),
        .raw          (dresp.data),
        .strobe       (strobe),
        .store_data   (store_data),
        .load_data    (load_data)
    );

    // Reset forces the IDLE decode so the bus and stall drop in the reset cycle itself.
    always_comb begin
        cur_state  = reset ? IDLE : state_q;
        access     = dataE.valid & (dataE.mem_read | dataE.mem_write);
        misaligned = access & is_misaligned(dataE.alu_result[2:0], dataE.msize);
        squash     = 1'b0;

        new_req        = '0;
        new_req.valid  = 1'b1;
        new_req.addr   = dataE.alu_result;
        new_req.size   = dataE.msize;
        new_req.strobe = dataE.mem_write ? strobe : 8'h00;
        new_req.data   = dataE.mem_write ? store_data : 64'h0;

        state_d         = state_q;
        flushed_d       = flushed_q;
        rdata_d         = rdata_q;
        dreq            = '0;
        handshake_stall = 1'b0;
        data_ok         = 1'b0;

        dataM.valid    = dataE.valid;
        dataM.pc       = dataE.pc;
        dataM.wdata    = dataE.alu_result;
        dataM.rd       = dataE.rd;
        dataM.regwrite = dataE.regwrite;
        dataM.exc      = EXC_NONE;

        unique case (cur_state)
            IDLE: begin
                flushed_d = 1'b0;
                if (misaligned)
                    dataM.exc = dataE.mem_write ? STORE_MISALIGN : LOAD_MISALIGN;
                if (access & ~misaligned & ~csr_flush & ~reset) begin
                    dreq            = new_req;
                    handshake_stall = 1'b1;
                    dataM.valid     = 1'b0;
                    if (dresp.data_ok) begin
                        rdata_d = load_data;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
                if (csr_flush)
                    dataM.valid = 1'b0;
            end
            BUSY: begin
                dreq            = new_req;
                handshake_stall = 1'b1;
                dataM.valid     = 1'b0;
                flushed_d       = flushed_q | csr_flush;
                if (dresp.data_ok) begin
                    rdata_d = load_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                squash      = flushed_q | csr_flush;
                dataM.valid = dataE.valid & ~squash;
                data_ok     = ~squash;
                if (dataE.mem_read)
                    dataM.wdata = rdata_q;
                flushed_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            state_d   = IDLE;
            flushed_d = 1'b0;
            rdata_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        flushed_q <= flushed_d;
        rdata_q   <= rdata_d;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for loads, stores,
// misalignment, flush and reset, checked with immediate assertions.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk;
    logic         reset;
    excute_data_t dataE;
    logic         csr_flush;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;
    memory_data_t dataM;
    logic         handshake_stall;
    logic         data_ok;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .dataE           (dataE),
        .csr_flush       (csr_flush),
        .dreq            (dreq),
        .dresp           (dresp),
        .dataM           (dataM),
        .handshake_stall (handshake_stall),
        .data_ok         (data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic excute_data_t mk(input logic rd_en, input logic wr_en, input msize_t sz,
                                        input logic uns, input logic [63:0] addr,
                                        input logic [63:0] rs2);
        excute_data_t d;
        d              = '0;
        d.valid        = 1'b1;
        d.pc           = 64'h0000_0000_0000_1000;
        d.mem_read     = rd_en;
        d.mem_write    = wr_en;
        d.msize        = sz;
        d.mem_unsigned = uns;
        d.alu_result   = addr;
        d.rs2_val      = rs2;
        d.rd           = 5'd10;
        d.regwrite     = rd_en;
        return d;
    endfunction

    task automatic set_resp(input logic ok, input logic [63:0] data);
        dresp.data_ok = ok;
        dresp.data    = data;
    endtask

    initial begin
        reset     = 1'b1;
        dataE     = '0;
        csr_flush = 1'b0;
        dresp     = '0;

        tick();
        tick();
        settle();
        $display("[TB] reset state");
        check_bit("rst_dreq_valid", dreq.valid, 1'b0);
        check("rst_dreq_addr", dreq.addr, 64'h0);
        check_bit("rst_stall", handshake_stall, 1'b0);
        check_bit("rst_data_ok", data_ok, 1'b0);
        check_bit("rst_dataM_valid", dataM.valid, 1'b0);
        check("rst_dataM_wdata", dataM.wdata, 64'h0);

        // Aligned LD with two cycles of bus latency
        tick();
        reset = 1'b0;
        dataE = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_0008, 64'h0);
        set_resp(1'b0, 64'h0);
        settle();
        $display("[TB] aligned LD");
        check_bit("ld_issue_valid", dreq.valid, 1'b1);
        check("ld_issue_addr", dreq.addr, 64'h8000_0008);
        check("ld_issue_strobe", 64'(dreq.strobe), 64'h0);
        check_bit("ld_stall_c0", handshake_stall, 1'b1);
        check_bit("ld_dataM_invalid_c0", dataM.valid, 1'b0);
        tick();
        settle();
        check_bit("ld_stall_c1", handshake_stall, 1'b1);
        check_bit("ld_hold_valid_c1", dreq.valid, 1'b1);
        tick();
        set_resp(1'b1, 64'h1122_3344_5566_7788);
        settle();
        check_bit("ld_stall_c2", handshake_stall, 1'b1);
        check_bit("ld_no_data_ok_c2", data_ok, 1'b0);
        tick();
        set_resp(1'b0, 64'h0);
        settle();
        check_bit("ld_stall_done", handshake_stall, 1'b0);
        check_bit("ld_dreq_done", dreq.valid, 1'b0);
        check_bit("ld_data_ok", data_ok, 1'b1);
        check_bit("ld_dataM_valid", dataM.valid, 1'b1);
        check("ld_wdata", dataM.wdata, 64'h1122_3344_5566_7788);
        tick();
        dataE = '0;
        settle();
        check_bit("ld_data_ok_pulse_end", data_ok, 1'b0);

        // Signed LB then back-to-back LBU, both with immediate response
        tick();
        dataE = mk(1'b1, 1'b0, MSIZE1, 1'b0, 64'h8000_0003, 64'h0);
        set_resp(1'b1, 64'h0000_0000_80FF_0000);
        settle();
        $display("[TB] LB / LBU");
        check_bit("lb_stall", handshake_stall, 1'b1);
        tick();
        set_resp(1'b0, 64'h0);
        settle();
        check("lb_wdata", dataM.wdata, 64'hFFFF_FFFF_FFFF_FF80);
        check_bit("lb_data_ok", data_ok, 1'b1);
        tick();
        dataE = mk(1'b1, 1'b0, MSIZE1, 1'b1, 64'h8000_0003, 64'h0);
        set_resp(1'b1, 64'h0000_0000_80FF_0000);
        settle();
        check_bit("lbu_no_bubble", dreq.valid, 1'b1);
        tick();
        set_resp(1'b0, 64'h0);
        settle();
        check("lbu_wdata", dataM.wdata, 64'h0000_0000_0000_0080);

        // SH formatting with immediate response
        tick();
        dataE = mk(1'b0, 1'b1, MSIZE2, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD);
        set_resp(1'b1, 64'h0);
        settle();
        $display("[TB] SH formatting");
        check("sh_strobe", 64'(dreq.strobe), 64'h0000_0000_0000_00C0);
        check("sh_data", dreq.data, 64'hABCD_0000_0000_0000);
        check("sh_size", 64'(dreq.size), 64'(MSIZE2));
        check_bit("sh_stall_c0", handshake_stall, 1'b1);
        tick();
        set_resp(1'b0, 64'h0);
        settle();
        check_bit("sh_stall_done", handshake_stall, 1'b0);
        check_bit("sh_data_ok", data_ok, 1'b1);
        check_bit("sh_dataM_valid", dataM.valid, 1'b1);

        // Misaligned LW and SD: no bus traffic, exception reported
        tick();
        dataE = mk(1'b1, 1'b0, MSIZE4, 1'b0, 64'h8000_0002, 64'h0);
        settle();
        $display("[TB] misaligned");
        check_bit("lw_mis_dreq", dreq.valid, 1'b0);
        check_bit("lw_mis_stall", handshake_stall, 1'b0);
        check_bit("lw_mis_valid", dataM.valid, 1'b1);
        check("lw_mis_exc", 64'(dataM.exc), 64'(LOAD_MISALIGN));
        check_bit("lw_mis_data_ok", data_ok, 1'b0);
        tick();
        dataE = mk(1'b0, 1'b1, MSIZE8, 1'b0, 64'h8000_0004, 64'h55);
        settle();
        check_bit("sd_mis_dreq", dreq.valid, 1'b0);
        check("sd_mis_exc", 64'(dataM.exc), 64'(STORE_MISALIGN));

        // Flush in IDLE suppresses issue
        tick();
        dataE     = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_0010, 64'h0);
        csr_flush = 1'b1;
        settle();
        $display("[TB] flush in IDLE");
        check_bit("flush_idle_dreq", dreq.valid, 1'b0);
        check_bit("flush_idle_stall", handshake_stall, 1'b0);
        check_bit("flush_idle_valid", dataM.valid, 1'b0);

        // Flush one cycle into BUSY; response arrives three cycles later
        tick();
        csr_flush = 1'b0;
        settle();
        $display("[TB] flush in BUSY");
        check_bit("fb_issue", dreq.valid, 1'b1);
        tick();
        csr_flush = 1'b1;
        settle();
        check_bit("fb_busy_valid", dreq.valid, 1'b1);
        check("fb_busy_addr", dreq.addr, 64'h8000_0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            csr_flush = 1'b0;
            if (i == 2) set_resp(1'b1, 64'hDEAD_BEEF_0000_0001);
            settle();
            check_bit("fb_hold_valid", dreq.valid, 1'b1);
            check("fb_hold_addr", dreq.addr, 64'h8000_0010);
            check_bit("fb_hold_stall", handshake_stall, 1'b1);
        end
        tick();
        set_resp(1'b0, 64'h0);
        settle();
        check_bit("fb_done_valid", dataM.valid, 1'b0);
        check_bit("fb_done_data_ok", data_ok, 1'b0);
        check_bit("fb_done_stall", handshake_stall, 1'b0);

        // Reset asserted while BUSY, then a normal LD
        tick();
        dataE = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_0018, 64'h0);
        settle();
        $display("[TB] reset mid-operation");
        check_bit("rb_issue", dreq.valid, 1'b1);
        tick();
        settle();
        check_bit("rb_busy", handshake_stall, 1'b1);
        tick();
        reset = 1'b1;
        dataE = '0;
        settle();
        check_bit("rb_in_reset_dreq", dreq.valid, 1'b0);
        check_bit("rb_in_reset_stall", handshake_stall, 1'b0);
        tick();
        reset = 1'b0;
        settle();
        check_bit("rb_after_dreq", dreq.valid, 1'b0);
        check_bit("rb_after_stall", handshake_stall, 1'b0);
        check_bit("rb_after_data_ok", data_ok, 1'b0);
        tick();
        dataE = mk(1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_0020, 64'h0);
        settle();
        check_bit("rb_ld_issue", dreq.valid, 1'b1);
        tick();
        set_resp(1'b1, 64'hCAFE_F00D_1234_5678);
        settle();
        check_bit("rb_ld_busy_stall", handshake_stall, 1'b1);
        tick();
        set_resp(1'b0, 64'h0);
        settle();
        check_bit("rb_ld_data_ok", data_ok, 1'b1);
        check("rb_ld_wdata", dataM.wdata, 64'hCAFE_F00D_1234_5678);
        tick();
        dataE = '0;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
